instr_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the 32-bit Memoria32 instance.
- Generates the word-aligned read address (`raddress`) and captures `Dataout` after a fixed read latency.
- Buffers fetched words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports a redirect (branch/jump) that flushes all in-flight and buffered words.

---
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: word-aligned address to Memoria32, MEM_LATENCY pipe, FIFO_DEPTH buffer to decode.
// Latency: first issue to valid_o is MEM_LATENCY+1 cycles; redirect flushes and restarts at the new PC.
// Backpressure: issue stalls while buffered + in-flight words fill the FIFO; optional FETCH_STATS_EN counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 1,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        Clk,
    input  logic        rst_n,
    output logic [31:0] raddress,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count_o,
    output logic [31:0] stall_count_o
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + MEM_LATENCY + 1);

    logic [31:0]            fetch_pc;
    logic [MEM_LATENCY-1:0] pipe_vld;
    logic [31:0]            pipe_pc [MEM_LATENCY];
    logic [31:0]            fifo_instr [FIFO_DEPTH];
    logic [31:0]            fifo_pc [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [CW-1:0]          fifo_cnt;
    logic [CW-1:0]          inflight;
    logic                   issue;
    logic                   push;
    logic                   pop;

    assign raddress = fetch_pc;
    assign valid_o  = (fifo_cnt != '0);
    assign pop      = valid_o && ready_i;
    // A response landing in a redirect cycle belongs to the abandoned path.
    assign push     = pipe_vld[MEM_LATENCY-1] && !redirect_i;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_vld[i]);
        end
        // Counting in-flight reads as credits means every response has a slot waiting.
        issue = !redirect_i && ((fifo_cnt + inflight) < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            pipe_vld <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_pc[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
            pipe_vld <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            pipe_vld[0] <= issue;
            pipe_pc[0]  <= fetch_pc;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_pc[i]  <= pipe_pc[i-1];
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: the pointers and count define what is live.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]    <= pipe_pc[MEM_LATENCY-1];
        end
    end

    assign instr_o = valid_o ? fifo_instr[rd_ptr] : '0;
    assign pc_o    = valid_o ? fifo_pc[rd_ptr]    : '0;

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (!rst_n) begin
            fetch_count_o <= '0;
            stall_count_o <= '0;
        end else begin
            if (push) begin
                fetch_count_o <= fetch_count_o + 32'd1;
            end
            if (valid_o && !ready_i) begin
                stall_count_o <= stall_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a 1-cycle synchronous Memoria32 model.
// Inputs change and outputs are sampled on the falling edge of Clk.
module tb_instr_fetch_unit;

    logic        Clk = 1'b0;
    logic        rst_n;
    logic [31:0] raddress;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_o;
    logic [31:0] stall_count_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) mem_rdata <= 32'hA500_0000 | raddress;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .MEM_LATENCY(1),
        .FIFO_DEPTH (4)
    ) dut (
        .Clk          (Clk),
        .rst_n        (rst_n),
        .raddress     (raddress),
        .mem_rdata    (mem_rdata),
        .instr_o      (instr_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count_o(fetch_count_o),
        .stall_count_o(stall_count_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge Clk);
        rst_n = 1'b1;
    endtask

    // A push into a full FIFO without a simultaneous pop is an overflow.
    always @(posedge Clk) begin
        if (rst_n && dut.push && (dut.fifo_cnt == 3'd4) && !(valid_o && ready_i))
            chk("overflow", 32'd1, 32'd0);
    end

    initial begin
        rst_n         = 1'b0;
        ready_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;

        // Test 1: reset values, then continuous streaming
        repeat (3) @(negedge Clk);
        chk("rst_raddr", raddress, 32'h0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_pc", pc_o, 32'h0);
        rst_n = 1'b1;
        @(negedge Clk);
        chk("t1_lat_valid", 32'(valid_o), 32'd0);
        chk("t1_raddr", raddress, 32'h4);
        @(negedge Clk);
        chk("t1_first_valid", 32'(valid_o), 32'd1);
        chk("t1_first_pc", pc_o, 32'h0);
        chk("t1_first_instr", instr_o, 32'hA500_0000);
        for (int k = 1; k <= 16; k++) begin
            @(negedge Clk);
            chk("t1_valid", 32'(valid_o), 32'd1);
            chk("t1_pc", pc_o, 32'(4 * k));
            chk("t1_instr", instr_o, 32'hA500_0000 | 32'(4 * k));
        end

        // Test 2: backpressure fills the FIFO, then drain in order
        ready_i = 1'b0;
        do_reset(2);
        @(negedge Clk);
        @(negedge Clk);
        chk("t2_valid", 32'(valid_o), 32'd1);
        chk("t2_pc0", pc_o, 32'h0);
        repeat (4) @(negedge Clk);
        chk("t2_raddr_stop", raddress, 32'h10);
        chk("t2_hold_pc", pc_o, 32'h0);
        chk("t2_hold_instr", instr_o, 32'hA500_0000);
        chk("t2_hold_valid", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge Clk);
            chk("t2_drain_valid", 32'(valid_o), 32'd1);
            chk("t2_drain_pc", pc_o, 32'(4 * k));
        end

        // Test 3: redirect with 2 buffered and 1 in flight
        ready_i = 1'b0;
        do_reset(1);
        repeat (3) @(negedge Clk);
        chk("t3_pre_valid", 32'(valid_o), 32'd1);
        chk("t3_pre_pc", pc_o, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0102;
        @(negedge Clk);
        chk("t3_flush_valid", 32'(valid_o), 32'd0);
        chk("t3_raddr", raddress, 32'h100);
        redirect_i = 1'b0;
        ready_i    = 1'b1;
        @(negedge Clk);
        chk("t3_gap_valid", 32'(valid_o), 32'd0);
        @(negedge Clk);
        chk("t3_new_valid", 32'(valid_o), 32'd1);
        chk("t3_new_pc", pc_o, 32'h100);
        chk("t3_new_instr", instr_o, 32'hA500_0100);
        @(negedge Clk);
        chk("t3_pc_104", pc_o, 32'h104);
        @(negedge Clk);
        chk("t3_pc_108", pc_o, 32'h108);

        // Test 4: address wrap across 2^32
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        @(negedge Clk);
        chk("t4_flush_valid", 32'(valid_o), 32'd0);
        chk("t4_raddr", raddress, 32'hFFFF_FFF8);
        redirect_i = 1'b0;
        @(negedge Clk);
        chk("t4_gap_valid", 32'(valid_o), 32'd0);
        @(negedge Clk);
        chk("t4_pc_fff8", pc_o, 32'hFFFF_FFF8);
        chk("t4_instr_fff8", instr_o, 32'hFFFF_FFF8);
        @(negedge Clk);
        chk("t4_pc_fffc", pc_o, 32'hFFFF_FFFC);
        @(negedge Clk);
        chk("t4_pc_0", pc_o, 32'h0);
        chk("t4_instr_0", instr_o, 32'hA500_0000);
        @(negedge Clk);
        chk("t4_pc_4", pc_o, 32'h4);

        // Test 5: one-cycle reset while full
        ready_i = 1'b0;
        repeat (6) @(negedge Clk);
        chk("t5_full_valid", 32'(valid_o), 32'd1);
        chk("t5_full_pc", pc_o, 32'h4);
        chk("t5_full_raddr", raddress, 32'h14);
        rst_n = 1'b0;
        @(negedge Clk);
        chk("t5_rst_valid", 32'(valid_o), 32'd0);
        chk("t5_rst_raddr", raddress, 32'h0);
        rst_n   = 1'b1;
        ready_i = 1'b1;
        @(negedge Clk);
        chk("t5_lat_valid", 32'(valid_o), 32'd0);
        @(negedge Clk);
        chk("t5_first_pc", pc_o, 32'h0);
        chk("t5_first_valid", 32'(valid_o), 32'd1);
        @(negedge Clk);
        chk("t5_pc_4", pc_o, 32'h4);
        @(negedge Clk);
        chk("t5_pc_8", pc_o, 32'h8);

`ifdef FETCH_STATS_EN
        // Test 6: 10 accepted words, 3 stalls, counters survive a redirect
        ready_i = 1'b1;
        do_reset(1);
        chk("t6_rst_fetch", fetch_count_o, 32'd0);
        chk("t6_rst_stall", stall_count_o, 32'd0);
        repeat (12) @(negedge Clk);
        chk("t6_fetch_11", fetch_count_o, 32'd11);
        chk("t6_stall_0", stall_count_o, 32'd0);
        chk("t6_head_40", pc_o, 32'h28);
        ready_i = 1'b0;
        repeat (3) @(negedge Clk);
        chk("t6_stall_3", stall_count_o, 32'd3);
        chk("t6_fetch_14", fetch_count_o, 32'd14);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        ready_i       = 1'b1;
        @(negedge Clk);
        redirect_i = 1'b0;
        chk("t6_redir_valid", 32'(valid_o), 32'd0);
        chk("t6_redir_stall", stall_count_o, 32'd3);
        chk("t6_redir_fetch", fetch_count_o, 32'd14);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
